rst_seq_ctrl: RTL and testbench

//   Parametrised reset controller for the user area. Merges N_SRC asynchronous

---
 rtl/rst_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the user area: synchronises, qualifies and masks reset requests,
// stretches the reset, then releases the domains one after another, lowest index first.
//
// state    | meaning
// ---------+------------------------------------------------------------
// HOLD     | a request is active; all domains held in reset
// STRETCH  | requests gone; counting the minimum reset stretch
// RELEASE  | releasing domains 0..r_idx, one more every STAGGER cycles
// RUN      | all domains out of reset
module rst_seq_ctrl #(
   parameter int N_SRC       = 4,
   parameter int N_DOM       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYC     = 8,
   parameter int STRETCH     = 16,
   parameter int STAGGER     = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_SRC-1:0] i_src_req,
   input  logic [N_SRC-1:0] i_src_en,
   input  logic [N_SRC-1:0] i_src_deb,
   input  logic             i_cause_clr,
   output logic [N_DOM-1:0] o_dom_rst,
   output logic             o_busy,
   output logic [N_SRC-1:0] o_cause,
   output logic             o_por
);

   localparam int DEB_W = $clog2(DEB_CYC + 1);
   localparam int STR_W = $clog2(STRETCH + 1);
   localparam int STG_W = $clog2(STAGGER + 1);
   localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYC);
   localparam logic [STR_W-1:0] STR_MAX  = STR_W'(STRETCH);
   localparam logic [STG_W-1:0] STG_MAX  = STG_W'(STAGGER);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((N_DOM > 1) ? N_DOM - 2 : 0);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_STRETCH,
      ST_RELEASE,
      ST_RUN
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync    [N_SRC];
   logic [DEB_W-1:0]       r_deb_cnt [N_SRC];
   logic [N_SRC-1:0]       w_s;
   logic [N_SRC-1:0]       w_act;
   logic                   w_any_act;

   state_t                 r_state, w_state_nxt;
   logic [STR_W-1:0]       r_str_cnt, w_str_nxt, w_str_inc;
   logic [STG_W-1:0]       r_stg_cnt, w_stg_nxt, w_stg_inc;
   logic [IDX_W-1:0]       r_idx, w_idx_nxt;
   logic [N_DOM-1:0]       w_dom_rst;
   logic [N_SRC-1:0]       r_cause;
   logic                   r_por;

   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         w_s[i] = r_sync[i][SYNC_STAGES-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_SRC; i++) begin
            r_sync[i]    <= '0;
            r_deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], i_src_req[i]};
            if (!w_s[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] != DEB_MAX) begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Enable gates combinationally so masking a live request takes effect on the next edge.
   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         w_act[i] = i_src_en[i] & (i_src_deb[i] ? (r_deb_cnt[i] >= DEB_MAX) : w_s[i]);
      end
   end

   assign w_any_act = |w_act;
   assign w_str_inc = r_str_cnt + 1'b1;
   assign w_stg_inc = r_stg_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_str_nxt   = r_str_cnt;
      w_stg_nxt   = r_stg_cnt;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_HOLD: begin
            w_str_nxt = '0;
            if (!w_any_act) w_state_nxt = ST_STRETCH;
         end
         ST_STRETCH: begin
            if (w_any_act) begin
               w_state_nxt = ST_HOLD;
            end else if (w_str_inc == STR_MAX) begin
               w_str_nxt   = '0;
               w_stg_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = (N_DOM == 1) ? ST_RUN : ST_RELEASE;
            end else begin
               w_str_nxt = w_str_inc;
            end
         end
         ST_RELEASE: begin
            if (w_any_act) begin
               w_state_nxt = ST_HOLD;
            end else if (w_stg_inc == STG_MAX) begin
               w_stg_nxt = '0;
               if (r_idx == IDX_LAST) w_state_nxt = ST_RUN;
               else                   w_idx_nxt   = r_idx + 1'b1;
            end else begin
               w_stg_nxt = w_stg_inc;
            end
         end
         ST_RUN: begin
            if (w_any_act) w_state_nxt = ST_HOLD;
         end
         default: w_state_nxt = ST_HOLD;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_STRETCH;
         r_str_cnt <= '0;
         r_stg_cnt <= '0;
         r_idx     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_str_cnt <= w_str_nxt;
         r_stg_cnt <= w_stg_nxt;
         r_idx     <= w_idx_nxt;
      end
   end

   always_comb begin
      w_dom_rst = '1;
      case (r_state)
         ST_RELEASE: begin
            for (int d = 0; d < N_DOM; d++) begin
               if (IDX_W'(d) <= r_idx) w_dom_rst[d] = 1'b0;
            end
         end
         ST_RUN:  w_dom_rst = '0;
         default: w_dom_rst = '1;
      endcase
   end

   // A new cause in the same cycle as a clear survives the clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cause <= '0;
         r_por   <= 1'b1;
      end else begin
         r_cause <= (i_cause_clr ? '0 : r_cause) | w_act;
         if (i_cause_clr) r_por <= 1'b0;
      end
   end

   assign o_dom_rst = w_dom_rst;
   assign o_busy    = (r_state != ST_RUN);
   assign o_cause   = r_cause;
   assign o_por     = r_por;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expected per-cycle domain resets are queued when
// stimulus is applied and compared one entry per clock.
module tb_rst_seq_ctrl;

   localparam int STAGGER = 4;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [3:0] i_src_req;
   logic [3:0] i_src_en;
   logic [3:0] i_src_deb;
   logic       i_cause_clr;
   logic [2:0] o_dom_rst;
   logic       o_busy;
   logic [3:0] o_cause;
   logic       o_por;

   typedef struct packed {
      logic [2:0] dom;
      logic       busy;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   rst_seq_ctrl dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_src_req   (i_src_req),
      .i_src_en    (i_src_en),
      .i_src_deb   (i_src_deb),
      .i_cause_clr (i_cause_clr),
      .o_dom_rst   (o_dom_rst),
      .o_busy      (o_busy),
      .o_cause     (o_cause),
      .o_por       (o_por)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] d, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.dom  = d;
         e.busy = |d;
         q.push_back(e);
      end
   endtask

   // pre cycles in RUN, hold cycles fully in reset, then the staggered release.
   task automatic rel_seq(input int pre, input int hold);
      push(3'b000, pre);
      push(3'b111, hold);
      push(3'b110, STAGGER);
      push(3'b100, STAGGER);
      push(3'b000, 3);
   endtask

   task automatic cyc(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(posedge i_clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("dom_rst", 32'(o_dom_rst), 32'(e.dom));
            chk("busy", 32'(o_busy), 32'(e.busy));
         end
      end
   endtask

   task automatic drain();
      while (q.size() > 0) cyc(1);
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_src_req   = 4'b0000;
      i_src_en    = 4'b0111;
      i_src_deb   = 4'b0100;
      i_cause_clr = 1'b0;

      // power-on
      for (int k = 0; k < 3; k++) begin
         @(posedge i_clk);
         #1;
         chk("por_dom", 32'(o_dom_rst), 32'h7);
         chk("por_busy", 32'(o_busy), 32'h1);
         chk("por_cause", 32'(o_cause), 32'h0);
         chk("por_flag", 32'(o_por), 32'h1);
      end
      i_rst_n = 1'b1;
      rel_seq(0, 15);
      drain();
      chk("por_flag_after", 32'(o_por), 32'h1);
      chk("por_cause_after", 32'(o_cause), 32'h0);

      // single-cycle pulse on src0
      rel_seq(2, 17);
      i_src_req[0] = 1'b1;
      cyc(1);
      i_src_req[0] = 1'b0;
      drain();
      chk("pulse_cause", 32'(o_cause), 32'h1);

      // debounced src2: 7 cycles is a glitch
      push(3'b000, 15);
      i_src_req[2] = 1'b1;
      cyc(7);
      i_src_req[2] = 1'b0;
      drain();
      chk("glitch7_cause", 32'(o_cause), 32'h1);

      // debounced src2: 8 cycles is accepted
      rel_seq(10, 17);
      i_src_req[2] = 1'b1;
      cyc(8);
      i_src_req[2] = 1'b0;
      drain();
      chk("deb8_cause", 32'(o_cause), 32'h5);

      // src1 arrives after domain 0 has released
      push(3'b000, 2);
      push(3'b111, 17);
      push(3'b110, 2);
      i_src_req[0] = 1'b1;
      cyc(1);
      i_src_req[0] = 1'b0;
      drain();
      push(3'b110, 2);
      push(3'b111, 21);
      push(3'b110, STAGGER);
      push(3'b100, STAGGER);
      push(3'b000, 3);
      i_src_req[1] = 1'b1;
      cyc(5);
      i_src_req[1] = 1'b0;
      drain();
      chk("midrel_cause", 32'(o_cause), 32'h7);

      // masked src3, then unmasked while held, then masked again to end it
      push(3'b000, 6);
      i_src_req[3] = 1'b1;
      drain();
      chk("mask_cause", 32'(o_cause), 32'h7);
      rel_seq(0, 18);
      i_src_en = 4'b1111;
      cyc(2);
      i_src_en = 4'b0111;
      drain();
      chk("unmask_cause", 32'(o_cause), 32'hf);
      i_src_req[3] = 1'b0;

      // clear coinciding with a src0 set, then a clear on its own
      rel_seq(2, 17);
      i_src_req[0] = 1'b1;
      cyc(1);
      i_src_req[0] = 1'b0;
      cyc(1);
      i_cause_clr = 1'b1;
      cyc(1);
      i_cause_clr = 1'b0;
      chk("clr_set_cause", 32'(o_cause), 32'h1);
      chk("clr_set_por", 32'(o_por), 32'h0);
      drain();
      i_cause_clr = 1'b1;
      cyc(1);
      i_cause_clr = 1'b0;
      chk("clr_cause", 32'(o_cause), 32'h0);
      chk("clr_por", 32'(o_por), 32'h0);

      // asynchronous reset assertion mid-cycle
      @(posedge i_clk);
      #3;
      i_rst_n = 1'b0;
      #1;
      chk("async_dom", 32'(o_dom_rst), 32'h7);
      chk("async_busy", 32'(o_busy), 32'h1);
      chk("async_por", 32'(o_por), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
